// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU command sequencer.
// ALU_SEQ_MOD_ZERO_CHECK_EN enables the modulo-by-zero flag helper.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_ABS = 3'd5,
    OP_AVG = 3'd6,
    OP_MOD = 3'd7
  } alu_op_e;

  localparam int unsigned ALU_LATENCY = 2;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] inst;
  } alu_cmd_t;

  localparam int unsigned CMD_W = $bits(alu_cmd_t);

`ifdef ALU_SEQ_MOD_ZERO_CHECK_EN
  function automatic logic is_mod_zero(input alu_cmd_t c);
    return (c.inst == OP_MOD) && (c.a == 8'h00);
  endfunction
`endif

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data and occupancy count.
// A write while full is refused even if a read happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic             wr_ok, rd_ok;

  assign full_o    = (count_q == FULL_CNT);
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rptr_q];

  assign wr_ok = wr_en_i && !full_o;
  assign rd_ok = rd_en_i && !empty_o;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (wr_ok) wptr_d = wptr_q + 1'b1;
    if (rd_ok) rptr_d = rptr_q + 1'b1;
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      if (wr_ok) mem_q[wptr_q] <= wr_data_i;
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command front-end for the 2-cycle ALU: command FIFO, credit-gated issue,
// in-flight tag pipe and in-order result FIFO. Option: ALU_SEQ_MOD_ZERO_CHECK_EN.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned CMD_DEPTH = 4,
  parameter int unsigned RES_DEPTH = 4
) (
  input  logic        clk_p_i,
  input  logic        reset_p_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [7:0]  cmd_a_i,
  input  logic [7:0]  cmd_b_i,
  input  logic [2:0]  cmd_inst_i,
  output logic [7:0]  alu_a_o,
  output logic [7:0]  alu_b_o,
  output logic [2:0]  alu_inst_o,
  input  logic [15:0] alu_result_i,
  output logic        res_valid_o,
  input  logic        res_ready_i,
  output logic [15:0] res_data_o,
  output logic [2:0]  res_inst_o,
`ifdef ALU_SEQ_MOD_ZERO_CHECK_EN
  output logic        res_err_o,
`endif
  output logic        busy_o
);

  localparam int unsigned CMD_CW = $clog2(CMD_DEPTH) + 1;
  localparam int unsigned RES_CW = $clog2(RES_DEPTH) + 1;
  localparam int unsigned STAGES = ALU_LATENCY + 1;
`ifdef ALU_SEQ_MOD_ZERO_CHECK_EN
  localparam int unsigned RES_W = 20;
`else
  localparam int unsigned RES_W = 19;
`endif
  localparam logic [RES_CW:0] RES_LIMIT = (RES_CW+1)'(RES_DEPTH);

  alu_cmd_t            cmd_in, cmd_head;
  logic                cmd_wr, cmd_full, cmd_empty;
  logic [CMD_CW-1:0]   cmd_count;

  logic                res_wr, res_full, res_empty;
  logic [RES_W-1:0]    res_wdata, res_rdata;
  logic [RES_CW-1:0]   res_count;

  logic [RES_CW:0]     credit_used;
  logic                issue;

  logic [STAGES-1:0]   pv_q, pv_d;
  logic [2:0]          ptag_q [STAGES];
  logic [2:0]          ptag_d [STAGES];
`ifdef ALU_SEQ_MOD_ZERO_CHECK_EN
  logic [STAGES-1:0]   pflag_q, pflag_d;
`endif
  logic [7:0]          alu_a_q, alu_a_d;
  logic [7:0]          alu_b_q, alu_b_d;
  logic [2:0]          alu_inst_q, alu_inst_d;

  // Ready is held low during reset so nothing is accepted while state clears.
  assign cmd_ready_o = !cmd_full && !reset_p_i;
  assign cmd_wr      = cmd_valid_i && cmd_ready_o;
  assign cmd_in      = {cmd_a_i, cmd_b_i, cmd_inst_i};

  sync_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk_i     (clk_p_i),
    .rst_i     (reset_p_i),
    .wr_en_i   (cmd_wr),
    .wr_data_i (cmd_in),
    .rd_en_i   (issue),
    .rd_data_o (cmd_head),
    .full_o    (cmd_full),
    .empty_o   (cmd_empty),
    .count_o   (cmd_count)
  );

  // Every in-flight op holds a result slot, so capture can never overflow.
  always_comb begin
    credit_used = {1'b0, res_count};
    for (int unsigned i = 0; i < STAGES; i++)
      credit_used = credit_used + (RES_CW+1)'(pv_q[i]);
  end

  assign issue = !cmd_empty && (credit_used < RES_LIMIT);

  always_comb begin
    pv_d       = {pv_q[STAGES-2:0], issue};
    ptag_d[0]  = issue ? cmd_head.inst : '0;
    for (int unsigned i = 1; i < STAGES; i++) ptag_d[i] = ptag_q[i-1];
`ifdef ALU_SEQ_MOD_ZERO_CHECK_EN
    pflag_d    = {pflag_q[STAGES-2:0], issue && is_mod_zero(cmd_head)};
`endif
    alu_a_d    = issue ? cmd_head.a    : '0;
    alu_b_d    = issue ? cmd_head.b    : '0;
    alu_inst_d = issue ? cmd_head.inst : '0;
  end

  always_ff @(posedge clk_p_i or posedge reset_p_i) begin
    if (reset_p_i) begin
      pv_q       <= '0;
      for (int unsigned i = 0; i < STAGES; i++) ptag_q[i] <= '0;
`ifdef ALU_SEQ_MOD_ZERO_CHECK_EN
      pflag_q    <= '0;
`endif
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_inst_q <= '0;
    end else begin
      pv_q       <= pv_d;
      ptag_q     <= ptag_d;
`ifdef ALU_SEQ_MOD_ZERO_CHECK_EN
      pflag_q    <= pflag_d;
`endif
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_inst_q <= alu_inst_d;
    end
  end

  assign alu_a_o    = alu_a_q;
  assign alu_b_o    = alu_b_q;
  assign alu_inst_o = alu_inst_q;

  assign res_wr = pv_q[STAGES-1];
`ifdef ALU_SEQ_MOD_ZERO_CHECK_EN
  assign res_wdata = {pflag_q[STAGES-1], ptag_q[STAGES-1],
                      pflag_q[STAGES-1] ? 16'hFFFF : alu_result_i};
`else
  assign res_wdata = {ptag_q[STAGES-1], alu_result_i};
`endif

  sync_fifo #(
    .WIDTH (RES_W),
    .DEPTH (RES_DEPTH)
  ) u_res_fifo (
    .clk_i     (clk_p_i),
    .rst_i     (reset_p_i),
    .wr_en_i   (res_wr),
    .wr_data_i (res_wdata),
    .rd_en_i   (res_ready_i),
    .rd_data_o (res_rdata),
    .full_o    (res_full),
    .empty_o   (res_empty),
    .count_o   (res_count)
  );

  assert property (@(posedge clk_p_i) disable iff (reset_p_i) res_wr |-> !res_full);

  assign res_valid_o = !res_empty;
  assign res_data_o  = res_empty ? '0 : res_rdata[15:0];
  assign res_inst_o  = res_empty ? '0 : res_rdata[18:16];
`ifdef ALU_SEQ_MOD_ZERO_CHECK_EN
  assign res_err_o   = !res_empty && res_rdata[19];
`endif

  assign busy_o = (cmd_count != '0) | (|pv_q) | (res_count != '0);

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer: a 2-cycle ALU model feeds the DUT,
// expected results are queued on command accept and checked by a monitor.
module tb_alu_cmd_sequencer;

  localparam int unsigned CMD_DEPTH = 4;
  localparam int unsigned RES_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid_i, cmd_ready_o;
  logic [7:0]  cmd_a_i, cmd_b_i;
  logic [2:0]  cmd_inst_i;
  logic [7:0]  alu_a_o, alu_b_o;
  logic [2:0]  alu_inst_o;
  logic [15:0] alu_result_i;
  logic        res_valid_o, res_ready_i;
  logic [15:0] res_data_o;
  logic [2:0]  res_inst_o;
  logic        busy_o;
`ifdef ALU_SEQ_MOD_ZERO_CHECK_EN
  logic        res_err_o;
`endif

  typedef struct {
    logic [15:0] d;
    logic [2:0]  op;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  int unsigned accepted    = 0;
  int unsigned ready_mode  = 1;   // 0 stall, 1 always ready, 2 random

  logic [15:0] s1 = '0, s2 = '0;
  logic [15:0] b2b_exp [8] = '{16'h001A, 16'h000E, 16'h0078, 16'h0004,
                               16'h0012, 16'h0006, 16'h000D, 16'h0002};

  alu_cmd_sequencer #(
    .CMD_DEPTH (CMD_DEPTH),
    .RES_DEPTH (RES_DEPTH)
  ) dut (
    .clk_p_i      (clk),
    .reset_p_i    (rst),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_a_i      (cmd_a_i),
    .cmd_b_i      (cmd_b_i),
    .cmd_inst_i   (cmd_inst_i),
    .alu_a_o      (alu_a_o),
    .alu_b_o      (alu_b_o),
    .alu_inst_o   (alu_inst_o),
    .alu_result_i (alu_result_i),
    .res_valid_o  (res_valid_o),
    .res_ready_i  (res_ready_i),
    .res_data_o   (res_data_o),
    .res_inst_o   (res_inst_o),
`ifdef ALU_SEQ_MOD_ZERO_CHECK_EN
    .res_err_o    (res_err_o),
`endif
    .busy_o       (busy_o)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  function automatic logic [15:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] op);
    case (op)
      3'd0:    return {8'h00, a} + {8'h00, b};
      3'd1:    return {8'h00, b} - {8'h00, a};
      3'd2:    return {8'h00, a} * {8'h00, b};
      3'd3:    return {8'h00, a & b};
      3'd4:    return {8'h00, a ^ b};
      3'd5:    return {8'h00, (a[7] ? -a : a)};
      3'd6:    return ({8'h00, a} + {8'h00, b}) >> 1;
      default: return (a == 8'h00) ? 16'h0000 : {8'h00, b % a};
    endcase
  endfunction

  function automatic exp_t ref_model(input logic [7:0] a, input logic [7:0] b,
                                     input logic [2:0] op);
    exp_t e;
    e.d   = alu_fn(a, b, op);
    e.op  = op;
    e.err = 1'b0;
`ifdef ALU_SEQ_MOD_ZERO_CHECK_EN
    if (op == 3'd7 && a == 8'h00) begin
      e.d   = 16'hFFFF;
      e.err = 1'b1;
    end
`endif
    return e;
  endfunction

  // ALU stage: operands seen in cycle n produce a result visible in cycle n+2.
  always @(posedge clk) begin
    s1 <= alu_fn(alu_a_o, alu_b_o, alu_inst_o);
    s2 <= s1;
  end
  assign alu_result_i = s2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                      input exp_t e, input int unsigned budget);
    int unsigned n = 0;
    bit done = 1'b0;
    while (!done) begin
      @(negedge clk);
      cmd_valid_i = 1'b1;
      cmd_a_i     = a;
      cmd_b_i     = b;
      cmd_inst_i  = op;
      if (cmd_ready_o) begin
        exp_q.push_back(e);
        accepted++;
        done = 1'b1;
      end else if (++n > budget) begin
        vectors++;
        miscompares++;
        $display("FAIL send_timeout: cmd_ready_o 0 for %0d cycles, required 1", n);
        done = 1'b1;
      end
    end
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(negedge clk);
      cmd_valid_i = 1'b0;
    end
  endtask

  task automatic wait_drain(input string name, input int unsigned budget);
    int unsigned n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
    idle(2);
    check({name, "_busy"}, 32'(busy_o), 32'd0);
  endtask

  // Monitor: drives consumer ready and checks each transferred result in order.
  initial begin
    exp_t e;
    res_ready_i = 1'b0;
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       res_ready_i = 1'b0;
        1:       res_ready_i = 1'b1;
        default: res_ready_i = 1'($urandom_range(0, 1));
      endcase
      if (!rst && res_valid_o && res_ready_i) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_result: got 0x%0h, required no result", res_data_o);
        end else begin
          e = exp_q.pop_front();
          check("res_data", 32'(res_data_o), 32'(e.d));
          check("res_inst", 32'(res_inst_o), 32'(e.op));
`ifdef ALU_SEQ_MOD_ZERO_CHECK_EN
          check("res_err", 32'(res_err_o), 32'(e.err));
`endif
        end
      end
    end
  end

  initial begin
    bit saw_valid;
    int unsigned acc0;
    logic [7:0] ra, rb;
    logic [2:0] rop;

    rst = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_a_i = '0;
    cmd_b_i = '0;
    cmd_inst_i = '0;

    repeat (2) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready_o), 32'd0);
    check("rst_res_valid", 32'(res_valid_o), 32'd0);
    check("rst_res_data", 32'({res_data_o, res_inst_o}), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_alu_ops", 32'({alu_a_o, alu_b_o, alu_inst_o}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_cmd_ready", 32'(cmd_ready_o), 32'd1);

    // Single op with latency checks.
    ready_mode = 1;
    send(8'd3, 8'd5, 3'd0, ref_model(8'd3, 8'd5, 3'd0), 10);
    idle(1);
    check("lat_e0_res_valid", 32'(res_valid_o), 32'd0);
    @(negedge clk);
    check("lat_e1_alu_ops", 32'({alu_a_o, alu_b_o, alu_inst_o}), 32'({8'd3, 8'd5, 3'd0}));
    repeat (2) begin
      @(negedge clk);
      check("lat_early_res_valid", 32'(res_valid_o), 32'd0);
    end
    @(negedge clk);
    check("lat_e4_res_valid", 32'(res_valid_o), 32'd1);
    check("lat_e4_res_data", 32'({res_data_o, res_inst_o}), 32'({16'h0008, 3'd0}));
    wait_drain("single_drain", 10);

    // Back-to-back, all opcodes, expected values from the table.
    for (int i = 0; i < 8; i++)
      send(8'h06, 8'h14, 3'(i), '{d: b2b_exp[i], op: 3'(i), err: 1'b0}, 20);
    idle(1);
    wait_drain("b2b_drain", 40);

    // Backpressure: 4 results held plus 4 buffered commands, then full.
    ready_mode = 0;
    acc0 = accepted;
    for (int i = 0; i < 8; i++) begin
      rop = 3'($urandom_range(0, 7));
      send(8'(i * 3 + 1), 8'(i + 9), rop, ref_model(8'(i * 3 + 1), 8'(i + 9), rop), 20);
    end
    idle(12);
    check("bp_accepted", accepted - acc0, CMD_DEPTH + RES_DEPTH);
    check("bp_cmd_ready_low", 32'(cmd_ready_o), 32'd0);
    check("bp_res_valid", 32'(res_valid_o), 32'd1);
    check("bp_head_data", 32'(res_data_o), 32'(exp_q[0].d));
    check("bp_busy", 32'(busy_o), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      cmd_valid_i = 1'b1;
      cmd_a_i = 8'hEE;
      cmd_b_i = 8'hEE;
      cmd_inst_i = 3'd0;
      check("full_ready_low", 32'(cmd_ready_o), 32'd0);
    end
    @(negedge clk);
    cmd_valid_i = 1'b0;
    ready_mode = 1;
    for (int i = 0; i < 2; i++)
      send(8'(40 + i), 8'(7 * i + 2), 3'(i + 1),
           ref_model(8'(40 + i), 8'(7 * i + 2), 3'(i + 1)), 30);
    idle(1);
    wait_drain("bp_drain", 60);

    // Reset while commands are in flight.
    for (int i = 0; i < 3; i++)
      send(8'(i + 1), 8'(i + 2), 3'd2, ref_model(8'(i + 1), 8'(i + 2), 3'd2), 10);
    idle(1);
    check("mid_busy_before", 32'(busy_o), 32'd1);
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("mid_rst_alu_ops", 32'({alu_a_o, alu_b_o, alu_inst_o}), 32'd0);
    check("mid_rst_outputs", 32'({res_valid_o, res_data_o, res_inst_o, busy_o, cmd_ready_o}), 32'd0);
    idle(2);
    rst = 1'b0;
    saw_valid = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (res_valid_o || busy_o) saw_valid = 1'b1;
    end
    check("mid_no_result_after", 32'(saw_valid), 32'd0);

`ifdef ALU_SEQ_MOD_ZERO_CHECK_EN
    send(8'h00, 8'h09, 3'd7, '{d: 16'hFFFF, op: 3'd7, err: 1'b1}, 10);
    idle(1);
    wait_drain("modzero_drain", 20);
`endif

    // Randomized traffic with random consumer stalls.
    ready_mode = 2;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle(1);
      end else begin
        ra  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
        rb  = 8'($urandom);
        rop = 3'($urandom_range(0, 7));
        send(ra, rb, rop, ref_model(ra, rb, rop), 50);
      end
    end
    idle(1);
    wait_drain("rand_drain", 200);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Command front-end wrapped around the 8-bit ALU stage. Accepts operand/opcode commands on a valid/ready interface, buffers them, issues them to the ALU (fixed 2-cycle latency), and captures returning results in order into a result buffer with its own valid/ready interface.
- Issue is credit-gated, so results are never dropped when the consumer stalls.

Parameters:
- CMD_DEPTH, 4: command FIFO entries; power of two, ≥2.
- RES_DEPTH, 4: result FIFO entries; power of two, ≥2. ≥4 needed for 1 result/cycle sustained.

Ports:
- clk_p_i  in  1  clock, rising edge.
- reset_p_i  in  1  asynchronous, active-high reset.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  command FIFO not full.
- cmd_a_i  in  8  operand A.
- cmd_b_i  in  8  operand B.
- cmd_inst_i  in  3  ALU opcode.
- alu_a_o  out  8  operand A to ALU, registered.
- alu_b_o  out  8  operand B to ALU, registered.
- alu_inst_o  out  3  opcode to ALU, registered.
- alu_result_i  in  16  ALU result.
- res_valid_o  out  1  result FIFO not empty.
- res_ready_i  in  1  consumer accepts result.
- res_data_o  out  16  head-of-FIFO result.
- res_inst_o  out  3  opcode that produced res_data_o.
- busy_o  out  1  any command buffered, in flight, or result pending.

Behaviour:
- **Reset.** Reset (async assert, sync release) clears:
  - both FIFOs and the in-flight pipe;
  - alu_a_o, alu_b_o, alu_inst_o = 0;
  - cmd_ready_o = 1 after reset releases (0 while reset_p_i is high); res_valid_o = 0; res_data_o = 0; res_inst_o = 0; busy_o = 0.
- **Reset mid-operation.** All buffered and in-flight commands are discarded. No result appears after release.
- **Command accept.**
  - A command is written when cmd_valid_i && cmd_ready_o at the clock edge.
  - cmd_ready_o = (cmd_count < CMD_DEPTH), combinational from registered state only.
  - Simultaneous write and read while full: the write is refused. Ready does not look ahead.
- **Issue.**
  - issue = cmd FIFO not empty && (inflight + res_count) < RES_DEPTH, where inflight = p0+p1+p2.
  - On issue, the head is popped and loaded into alu_*_o, and pipe bit p0 is set with the opcode tag.
  - With no issue, alu_*_o are driven to 0 (opcode 000), p0 = 0.
  - Pipe timing:
    - p0 marks operands valid on alu_*_o in cycle n.
    - p1 marks cycle n+1.
    - p2 marks cycle n+2; alu_result_i is valid during cycle n+2.
- **Capture.** At the end of a cycle with p2 = 1, alu_result_i and the p2 tag are pushed into the result FIFO. The credit rule guarantees this push never hits a full FIFO.
- **Result pop.** Pop on res_valid_o && res_ready_i. Push and pop in the same cycle leave res_count unchanged.
- **Minimum latency.** Command accepted at edge E0:
  - alu_*_o update at E1;
  - result captured at E4;
  - res_valid_o = 1 after E4.
- **Ordering.** Results leave in strict command order.
- **Pointers.** Wrap modulo depth; counters are log2(depth)+1 bits wide.
- **busy_o** = (cmd_count != 0) | p0 | p1 | p2 | (res_count != 0).

Optional Feature:
- Macro ALU_SEQ_MOD_ZERO_CHECK_EN.
- When defined:
  - each in-flight entry also carries the flag (inst==3'b111 && a==8'h00);
  - on capture of a flagged entry, 16'hFFFF is stored instead of alu_result_i;
  - an extra output res_err_o (1 bit) is added, high with the head result when that result was flagged; reset value 0.
- When undefined: no flag, no port; ALU result is stored unchanged.

Decomposition:
- Package alu_seq_pkg holds:
  - opcode constants OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_AND=3, OP_XOR=4, OP_ABS=5, OP_AVG=6, OP_MOD=7;
  - ALU_LATENCY=2;
  - the command struct typedef {a[7:0], b[7:0], inst[2:0]}.
- Sub-module: sync_fifo (parameterised WIDTH/DEPTH, full/empty/count), instantiated twice: command (19 bits) and result (19 bits, 20 with the feature).

Test Plan:
- **Single op.** After reset, cmd a=3, b=5, inst=0 → alu_*_o = 3/5/0 one cycle after accept; ALU model returns 16'h0008; res_valid_o rises 4 cycles after accept with res_data_o=16'h0008, res_inst_o=0.
- **Back-to-back.** 8 commands (inst 0..7, a=8'h06, b=8'h14), res_ready_i=1 → results in order (0x001A, 0x000E, 0x0078, 0x0004, 0x0012, 0x0006, 0x000D, 0x0002), one per cycle after the first.
- **Backpressure.** res_ready_i=0, 10 commands pushed → at most RES_DEPTH=4 results held, cmd_ready_o drops once 4 commands are buffered, nothing lost; releasing res_ready_i drains all 10 in order.
- **FIFO full.** Hold cmd_valid_i=1 with results stalled → cmd_ready_o=0 exactly when cmd_count=4; a write attempted that cycle is not accepted.
- **Reset mid-flight.** Pulse reset_p_i while 3 commands are in flight → all outputs at reset values immediately; no res_valid_o afterwards; busy_o=0.
- **Feature on.** a=0, b=9, inst=7 → res_data_o=16'hFFFF, res_err_o=1.
